// File: rtl/fdc_flop.sv
// Leaf D flip-flop bank with synchronous active-low clear; q follows d one clock later.
// No flow control: the register captures d or clears on every rising edge of clock.
module fdc_flop #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clock,
  input  logic             clear_n,
  output logic [WIDTH-1:0] q
);

  // Clear wins over data at the same edge; q comes straight off the flops.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_fdc_flop.sv
// Directed bench for fdc_flop: a 1-bit default instance and an 8-bit instance with reset value 0xA5.
module tb_fdc_flop;

  logic       clock;
  logic       clear_n1, clear_n8;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each register must hold after the most recent rising edge.
  logic       exp1;
  logic [7:0] exp8;
  bit         model_vld = 0;

  fdc_flop u_dut1 (
    .d       (d1),
    .clock   (clock),
    .clear_n (clear_n1),
    .q       (q1)
  );

  fdc_flop #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .d       (d8),
    .clock   (clock),
    .clear_n (clear_n8),
    .q       (q8)
  );

  initial clock = 1'b0;
  always #25 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: at an edge, clear selects the reset value, otherwise the register takes d.
  always @(posedge clock) begin
    exp1      = clear_n1 ? d1 : 1'b0;
    exp8      = clear_n8 ? d8 : 8'hA5;
    model_vld = 1'b1;
  end

  // Inputs are driven during the high phase, so any path that bypasses the edge shows up here.
  always @(negedge clock) begin
    if (model_vld) begin
      chk("model_q1", {63'd0, q1}, {63'd0, exp1});
      chk("model_q8", {56'd0, q8}, {56'd0, exp8});
    end
  end

  // Applied 10 units after a rising edge and held for 100 units (two edges).
  // Checks q just before the next edge (old value) and just after it (new value).
  task automatic step(input string name,
                      input logic cn1, input logic dd1, input logic cn8, input logic [7:0] dd8,
                      input logic pre1, input logic post1,
                      input logic [7:0] pre8, input logic [7:0] post8);
    clear_n1 = cn1;
    d1       = dd1;
    clear_n8 = cn8;
    d8       = dd8;
    #30;
    chk({name, "_pre_q1"}, {63'd0, q1}, {63'd0, pre1});
    chk({name, "_pre_q8"}, {56'd0, q8}, {56'd0, pre8});
    #20;
    chk({name, "_post_q1"}, {63'd0, q1}, {63'd0, post1});
    chk({name, "_post_q8"}, {56'd0, q8}, {56'd0, post8});
    #50;
  endtask

  initial begin
    clear_n1 = 1'b0;
    clear_n8 = 1'b0;
    d1       = 1'b0;
    d8       = 8'h00;

    // First edge at t=25 initialises both registers.
    #35;
    chk("reset_q1", {63'd0, q1}, 64'h0);
    chk("reset_q8", {56'd0, q8}, 64'hA5);

    //   name         cn1  d1   cn8  d8      pre1 post1 pre8   post8
    step("clr_d0",    0,   0,   0,   8'h3C,  0,   0,    8'hA5, 8'hA5);
    step("run_d0",    1,   0,   1,   8'h3C,  0,   0,    8'hA5, 8'h3C);
    step("run_d1",    1,   1,   1,   8'hFF,  0,   1,    8'h3C, 8'hFF);
    step("clr_from1", 0,   0,   0,   8'h00,  1,   0,    8'hFF, 8'hA5);
    step("clr_prio",  0,   1,   0,   8'hFF,  0,   0,    8'hA5, 8'hA5);
    step("release",   1,   1,   1,   8'h5A,  0,   1,    8'hA5, 8'h5A);
    step("run_fall",  1,   0,   1,   8'h81,  1,   0,    8'h5A, 8'h81);
    step("clr_hold",  0,   1,   0,   8'h7E,  0,   0,    8'h81, 8'hA5);
    step("rel_again", 1,   1,   1,   8'h11,  0,   1,    8'hA5, 8'h11);

    // Toggle d mid-way through the high phase; q must wait for the next rising edge.
    @(posedge clock);
    #12;
    d1 = 1'b0;
    d8 = 8'hEE;
    #8;
    chk("mid_high_q1", {63'd0, q1}, 64'h1);
    chk("mid_high_q8", {56'd0, q8}, 64'h11);
    @(posedge clock);
    #5;
    chk("next_edge_q1", {63'd0, q1}, 64'h0);
    chk("next_edge_q8", {56'd0, q8}, 64'hEE);

    // Clear dropped mid-cycle must not act before the edge.
    #10;
    clear_n1 = 1'b0;
    clear_n8 = 1'b0;
    d1       = 1'b1;
    #5;
    chk("clr_async_q1", {63'd0, q1}, 64'h0);
    chk("clr_async_q8", {56'd0, q8}, 64'hEE);
    @(posedge clock);
    #5;
    chk("clr_edge_q8", {56'd0, q8}, 64'hA5);

    #60;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fdc_flop.md
FDC_FLOP -- requirements
Module: fdc_flop

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits; legal range 1..64.
REQ-002 Parameter RESET_VALUE, default all-zeros, WIDTH bits: value loaded into q on clear.
REQ-003 Port clock, input, 1 bit: single clock; all state changes on its rising edge only.
REQ-004 Port clear_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port d, input, WIDTH bits: data captured on each rising clock edge when clear_n is high.
REQ-006 Port q, output, WIDTH bits: registered output.
REQ-007 Positional port order SHALL be d, clock, clear_n, q, so that existing positional instantiations (data, clock, clear, output) bind correctly.

Function
REQ-008 At each rising edge of clock with clear_n = 1, q SHALL take the value d had at that edge (one-cycle latency).
REQ-009 At each rising edge of clock with clear_n = 0, q SHALL become RESET_VALUE regardless of d.
REQ-010 Clear SHALL take priority over data when both are presented at the same edge.
REQ-011 q SHALL NOT change between rising edges; changes on d or clear_n alone (including the falling clock edge) SHALL have no effect.
REQ-012 q SHALL be driven directly from the storage element, with no combinational path from d or clear_n to q.
REQ-013 When clear_n is deasserted (0 -> 1), the first edge with clear_n = 1 SHALL capture d normally; no extra recovery cycle is required.
REQ-014 Holding clear_n low for multiple edges SHALL keep q at RESET_VALUE.
REQ-015 Before the first rising edge, q is unspecified; users SHALL apply clear_n = 0 for at least one edge to initialise.

Reset
REQ-016 Reset SHALL be fully synchronous; no asynchronous clear or preset path.
REQ-017 The reset value of q SHALL be RESET_VALUE (0 by default).

Structure
REQ-018 No shared package is required; WIDTH and RESET_VALUE are local parameters of this module.
REQ-019 The block SHALL be a single module with no sub-modules.
REQ-020 The module SHALL be a leaf primitive that other registers, counters and the CPU datapath instantiate.
REQ-021 The module SHALL contain exactly WIDTH flip-flops and no other state.

Verification
REQ-022 The bench SHALL run with a 50-time-unit clock period (25 units high, 25 units low) and hold each stimulus for 100 units (two edges).
REQ-023 Scenario: clear_n = 0, d = 0 -> q = 0 after the first rising edge.
REQ-024 Scenario: clear_n = 1, d = 0 -> q remains 0.
REQ-025 Scenario: clear_n = 1, d = 1 -> q = 1 at the next rising edge, and not before it.
REQ-026 Scenario: q = 1, then clear_n = 0 with d = 0 -> q = 0 at the next rising edge.
REQ-027 Scenario: clear_n = 0, d = 1 -> q stays 0 (clear priority); then clear_n = 1 with d held at 1 -> q = 1 at the following edge.
REQ-028 Scenario: toggle d midway through the clock-high phase -> q unchanged until the next rising edge.
REQ-029 Scenario: WIDTH = 8, RESET_VALUE = 0xA5; clear_n = 0 -> q = 0xA5; then clear_n = 1, d = 0x3C -> q = 0x3C after one edge.
